dm_store_buffer: RTL and testbench

- Word-addressed store buffer between the MEM-stage store path and the DM write port.
- Accepts stores from the pipeline, queues them in program order, and drains one per cycle to DM when the write port is granted.
- Forwards buffered full-word store data to same-address loads; requests a stall when only a partial-byte store matches.
- Lets stores retire without waiting on the DM write slot.

---
 rtl/sb_defs.sv | 18 +
 rtl/sb_fwd_match.sv | 51 +++++
 rtl/dm_store_buffer.sv | 139 +++++++++++++
 tb/tb_dm_store_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_defs.sv
// Shared definitions for the DM store buffer.
// Each entry record is laid out as {valid, waddr, data, be, pc}; waddr is the
// word address (byte address with bits [1:0] dropped), so its width depends on ADDR_W.
package sb_defs;

   localparam logic [3:0] BE_WORD  = 4'hF;
   localparam int         SB_DEPTH = 4;

   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   localparam int PC_W   = 32;

   // Only a store that writes all four byte lanes can supply a whole loaded word.
   function automatic logic be_is_word(input logic [BE_W-1:0] be);
      return be == BE_WORD;
   endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the store buffer for load forwarding.
// The search walks from the head (oldest) toward the tail. The last valid
// entry that matches wins, because it is the youngest store to that word.
module sb_fwd_match
   import sb_defs::*;
#(
   parameter int DEPTH   = SB_DEPTH,
   parameter int WADDR_W = 30
) (
   input  logic [WADDR_W-1:0]              ld_waddr,
   input  logic [$clog2(DEPTH)-1:0]        head,
   input  logic [DEPTH-1:0]                ent_valid,
   input  logic [DEPTH-1:0][WADDR_W-1:0]   ent_waddr,
   input  logic [DEPTH-1:0][DATA_W-1:0]    ent_data,
   input  logic [DEPTH-1:0][BE_W-1:0]      ent_be,
   output logic                            hit,
   output logic                            stall,
   output logic [DATA_W-1:0]               data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  idx;
   logic              found;
   logic [BE_W-1:0]   found_be;
   logic [DATA_W-1:0] found_data;

   // Priority search in age order: a later match overrides an earlier one.
   always_comb begin
      idx        = '0;
      found      = 1'b0;
      found_be   = '0;
      found_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + i[PTR_W-1:0];
         if (ent_valid[idx] && (ent_waddr[idx] == ld_waddr)) begin
            found      = 1'b1;
            found_be   = ent_be[idx];
            found_data = ent_data[idx];
         end
      end
   end

   // A full-word youngest match forwards its data; a partial one forces a stall.
   always_comb begin
      hit   = found && be_is_word(found_be);
      stall = found && !be_is_word(found_be);
      data  = hit ? found_data : '0;
   end

endmodule

// File: rtl/dm_store_buffer.sv
// Word-addressed store buffer between the MEM-stage store path and the DM write port.
// Stores are queued in program order and drain one per granted cycle. Loads are
// forwarded from the youngest full-word match.
// Optional feature: define STORE_TRACE_EN to print a judge-format trace line
// ("@pc: *addr <= data") at each edge where a store pops into DM.
module dm_store_buffer
   import sb_defs::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      st_valid,
   output logic                      st_ready,
   input  logic [ADDR_W-1:0]         st_addr,
   input  logic [DATA_W-1:0]         st_data,
   input  logic [BE_W-1:0]           st_be,
   input  logic [PC_W-1:0]           st_pc,
   input  logic                      ld_valid,
   input  logic [ADDR_W-1:0]         ld_addr,
   output logic                      ld_hit,
   output logic [DATA_W-1:0]         ld_data,
   output logic                      ld_stall,
   output logic                      dm_we,
   output logic [ADDR_W-1:0]         dm_addr,
   output logic [DATA_W-1:0]         dm_wd,
   output logic [BE_W-1:0]           dm_be,
   output logic [PC_W-1:0]           dm_pc,
   input  logic                      dm_gnt,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int WADDR_W = ADDR_W - 2;

   logic [DEPTH-1:0]                ent_valid;
   logic [DEPTH-1:0][WADDR_W-1:0]   ent_waddr;
   logic [DEPTH-1:0][DATA_W-1:0]    ent_data;
   logic [DEPTH-1:0][BE_W-1:0]      ent_be;
   logic [DEPTH-1:0][PC_W-1:0]      ent_pc;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   logic push;
   logic pop;

   logic              fwd_hit;
   logic              fwd_stall;
   logic [DATA_W-1:0] fwd_data;

   // Byte-offset bits never take part in word matching or storage.
   logic unused_byte_off;
   assign unused_byte_off = ^{st_addr[1:0], ld_addr[1:0]};

   // Occupancy flags and the head-entry view presented to the DM write port.
   always_comb begin
      empty    = (count == '0);
      st_ready = (count != CNT_W'(DEPTH));
      dm_we    = !empty;
      dm_addr  = {ent_waddr[head], 2'b00};
      dm_wd    = ent_data[head];
      dm_be    = ent_be[head];
      dm_pc    = ent_pc[head];
      push     = st_valid && st_ready;
      pop      = dm_we && dm_gnt;
   end

   // FIFO storage, pointers and count. A push and a pop never target the same
   // slot, because a pop needs count>0 and a push needs count<DEPTH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
         ent_waddr <= '0;
         ent_data  <= '0;
         ent_be    <= '0;
         ent_pc    <= '0;
      end else begin
         if (pop) begin
            ent_valid[head] <= 1'b0;
            head            <= head + PTR_W'(1);
         end
         if (push) begin
            ent_valid[tail] <= 1'b1;
            ent_waddr[tail] <= st_addr[ADDR_W-1:2];
            ent_data[tail]  <= st_data;
            ent_be[tail]    <= st_be;
            ent_pc[tail]    <= st_pc;
            tail            <= tail + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   sb_fwd_match #(
      .DEPTH   (DEPTH),
      .WADDR_W (WADDR_W)
   ) u_fwd (
      .ld_waddr  (ld_addr[ADDR_W-1:2]),
      .head      (head),
      .ent_valid (ent_valid),
      .ent_waddr (ent_waddr),
      .ent_data  (ent_data),
      .ent_be    (ent_be),
      .hit       (fwd_hit),
      .stall     (fwd_stall),
      .data      (fwd_data)
   );

   // A store arriving alongside a load stalls the load for one cycle.
   // On the retry, the load sees the new entry.
   always_comb begin
      ld_hit   = ld_valid && !st_valid && fwd_hit;
      ld_stall = ld_valid && (st_valid || fwd_stall);
      ld_data  = ld_hit ? fwd_data : '0;
   end

`ifdef STORE_TRACE_EN
   // Report each store as it reaches memory, in the course-judge trace format.
   always_ff @(posedge clk) begin
      if (reset && pop) begin
         $display("@%h: *%h <= %h", dm_pc, dm_addr, dm_wd);
      end
   end
`else
   // No trace. st_pc still rides along with each entry and appears on dm_pc.
`endif

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer. Reference model: an in-order queue of stores.
module tb_dm_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_be;
   logic [31:0] st_pc;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        ld_stall;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wd;
   logic [3:0]  dm_be;
   logic [31:0] dm_pc;
   logic        dm_gnt;
   logic [2:0]  count;
   logic        empty;

   dm_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .st_valid (st_valid),
      .st_ready (st_ready),
      .st_addr  (st_addr),
      .st_data  (st_data),
      .st_be    (st_be),
      .st_pc    (st_pc),
      .ld_valid (ld_valid),
      .ld_addr  (ld_addr),
      .ld_hit   (ld_hit),
      .ld_data  (ld_data),
      .ld_stall (ld_stall),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wd    (dm_wd),
      .dm_be    (dm_be),
      .dm_pc    (dm_pc),
      .dm_gnt   (dm_gnt),
      .count    (count),
      .empty    (empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] waddr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] pc;
   } ent_t;

   ent_t        q[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] pc_ctr = 32'h0000_1000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check all outputs against the queue model for the inputs now applied.
   task automatic check_outputs(input logic sv, input logic lv, input logic [31:0] la);
      int          n;
      logic        eh;
      logic        es;
      logic [31:0] ed;
      n  = q.size();
      eh = 1'b0;
      es = 1'b0;
      ed = 32'h0;
      chk("st_ready", {31'h0, st_ready}, (n < DEPTH) ? 32'd1 : 32'd0);
      chk("count", {29'h0, count}, 32'(n));
      chk("empty", {31'h0, empty}, (n == 0) ? 32'd1 : 32'd0);
      chk("dm_we", {31'h0, dm_we}, (n > 0) ? 32'd1 : 32'd0);
      if (n > 0) begin
         chk("dm_addr", dm_addr, {q[0].waddr, 2'b00});
         chk("dm_wd", dm_wd, q[0].data);
         chk("dm_be", {28'h0, dm_be}, {28'h0, q[0].be});
         chk("dm_pc", dm_pc, q[0].pc);
      end
      if (lv) begin
         if (sv) begin
            es = 1'b1;
         end else begin
            for (int i = n - 1; i >= 0; i--) begin
               if (q[i].waddr == la[31:2]) begin
                  if (q[i].be == 4'hF) begin
                     eh = 1'b1;
                     ed = q[i].data;
                  end else begin
                     es = 1'b1;
                  end
                  break;
               end
            end
         end
      end
      chk("ld_hit", {31'h0, ld_hit}, {31'h0, eh});
      chk("ld_stall", {31'h0, ld_stall}, {31'h0, es});
      chk("ld_data", ld_data, ed);
   endtask

   // One clock cycle: drive inputs, check outputs, take the edge, then update the model.
   task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [3:0] sb, input logic lv, input logic [31:0] la,
                       input logic g);
      logic do_push;
      logic do_pop;
      ent_t e;
      st_valid = sv;
      st_addr  = sa;
      st_data  = sd;
      st_be    = sb;
      st_pc    = pc_ctr;
      ld_valid = lv;
      ld_addr  = la;
      dm_gnt   = g;
      #1;
      check_outputs(sv, lv, la);
      do_push = sv && (q.size() < DEPTH);
      do_pop  = g && (q.size() > 0);
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
         e.waddr = sa[31:2];
         e.data  = sd;
         e.be    = sb;
         e.pc    = pc_ctr;
         q.push_back(e);
      end
      pc_ctr = pc_ctr + 32'd4;
      #1;
   endtask

   task automatic idle(input logic g);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, g);
   endtask

   task automatic drain();
      for (int k = 0; k < DEPTH + 2; k++) idle(1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b0;
      st_valid = 1'b0;
      st_addr  = '0;
      st_data  = '0;
      st_be    = '0;
      st_pc    = '0;
      ld_valid = 1'b0;
      ld_addr  = '0;
      dm_gnt   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", {29'h0, count}, 32'd0);
      chk("rst_empty", {31'h0, empty}, 32'd1);
      chk("rst_dm_we", {31'h0, dm_we}, 32'd0);
      chk("rst_ld_hit", {31'h0, ld_hit}, 32'd0);
      chk("rst_ld_stall", {31'h0, ld_stall}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // A single store shows up on the DM port one cycle later, then the buffer empties.
      step(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b1);
      chk("t1_dm_addr", dm_addr, 32'h10);
      chk("t1_dm_wd", dm_wd, 32'hDEADBEEF);
      idle(1'b1);
      chk("t1_empty", {31'h0, empty}, 32'd1);

      // Fill to full; the fifth store is held, then drains in order.
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 1'b0, 32'h0, 1'b0);
      chk("t2_full_ready", {31'h0, st_ready}, 32'd0);
      step(1'b1, 32'h40, 32'h5555_5555, 4'hF, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 6; i++)
         step((q.size() < DEPTH && i > 1) ? 1'b0 : 1'b1, 32'h40, 32'h5555_5555, 4'hF,
              1'b0, 32'h0, 1'b1);
      drain();

      // The youngest full-word store forwards; an unrelated address misses.
      step(1'b1, 32'h20, 32'h1111_1111, 4'hF, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h20, 32'h2222_2222, 4'hF, 1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20, 1'b0);
      chk("t3_fwd_data", ld_data, 32'h2222_2222);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h24, 1'b0);
      drain();

      // A partial store stalls the load until it drains.
      step(1'b1, 32'h24, 32'h0000_BEEF, 4'b0011, 1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h24, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h24, 1'b1);

      // Steady state at count=3 with a push and a pop every cycle.
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h80 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'hF, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++)
         step(1'b1, 32'h90 + 32'(i * 4), 32'hD000_0000 + 32'(i), 4'hF, 1'b0, 32'h0, 1'b1);
      chk("t5_count", {29'h0, count}, 32'd3);
      drain();

      // A store in the same cycle as a load forces a stall; the retry forwards.
      step(1'b1, 32'h30, 32'h3333_3333, 4'hF, 1'b1, 32'h30, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h30, 1'b0);
      drain();

      // Randomized traffic over a small address window so matches are frequent.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] be;
         be = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 14));
         step(($urandom_range(0, 2) != 0),
              32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
              $urandom, be,
              ($urandom_range(0, 1) == 1),
              32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0));
      end
      drain();

      // Reset asserted mid-cycle with three entries buffered.
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'hC0 + 32'(i * 4), 32'hE000_0000 + 32'(i), 4'hF, 1'b0, 32'h0, 1'b0);
      st_valid = 1'b0;
      ld_valid = 1'b0;
      dm_gnt   = 1'b1;
      reset    = 1'b0;
      #1;
      chk("t6_dm_we", {31'h0, dm_we}, 32'd0);
      chk("t6_count", {29'h0, count}, 32'd0);
      chk("t6_empty", {31'h0, empty}, 32'd1);
      q.delete();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      idle(1'b1);
      step(1'b1, 32'h44, 32'h4444_4444, 4'hF, 1'b0, 32'h0, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
